// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM pattern tester.
//   state_t    : tester FSM encoding
//   PAT_*      : pat_sel encodings
//   LFSR_TAPS  : Galois feedback mask for taps 32, 22, 2, 1
//   lfsr_step  : one right-shifting Galois LFSR step
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] PAT_INC   = 2'd0;
  localparam logic [1:0] PAT_ADDR  = 2'd1;
  localparam logic [1:0] PAT_WALK1 = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/tester_pattern_gen.sv
// Data pattern generator shared by the write and read phases, so the data
// written to a word and the data expected back from it come from the same
// logic.
//   clk100, rst_p : clock, asynchronous active-high reset
//   load          : restart the sequence at the first word of a phase
//   advance       : step to the next word
//   pat_sel, seed : pattern selection and seed (next-cycle values)
//   addr, idx     : address and index of the word the pattern is for
//   pattern       : registered pattern for the current command word
// addr/idx/seed/pat_sel are the values the tester is about to register, so
// pattern lines up with cmd_address in the same cycle.
module tester_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int AW = 23,
  parameter int DW = 32
) (
  input  logic          clk100,
  input  logic          rst_p,
  input  logic          load,
  input  logic          advance,
  input  logic [1:0]    pat_sel,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] idx,
  output logic [DW-1:0] pattern
);

  logic [31:0]   lfsr_q, lfsr_d;
  logic [DW-1:0] pattern_q, pattern_d;
  logic [31:0]   seed32;
  logic [DW-1:0] walk_one;

  assign seed32   = 32'(seed);
  assign walk_one = DW'(1) << (32'(idx) % DW);

  always_comb begin
    lfsr_d    = lfsr_q;
    pattern_d = pattern_q;
    // The LFSR value for word k is the state after k steps from the seed;
    // an all-zero seed would lock the register, so it is replaced by 1.
    if (load) begin
      lfsr_d = (seed32 == 32'd0) ? 32'd1 : seed32;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
    if (load || advance) begin
      case (pat_sel)
        PAT_INC:   pattern_d = seed + DW'(idx);
        PAT_ADDR:  pattern_d = DW'(addr);
        PAT_WALK1: pattern_d = walk_one;
        default:   pattern_d = DW'(lfsr_d);
      endcase
    end
  end

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      lfsr_q    <= 32'd0;
      pattern_q <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test engine: writes a programmable window with a selectable
// pattern, reads it back and compares, reporting pass/fail, a saturating
// error count and the first miscompare.
//   clk100, rst_p            : clock, asynchronous active-high reset
//   start, abort             : single-cycle control requests
//   pat_sel, seed            : pattern configuration (sampled at start)
//   addr_lo, addr_hi         : inclusive address window (sampled at start)
//   cmd_*                    : command port towards the SDRAM controller
//   data_out, data_out_ready : read return from the controller
//   busy, done, pass, cfg_err, aborted, err_count, first_err_* : status
// Command handshake: a command is transferred in a cycle where
// cmd_enable=1 and cmd_ready=1; until then cmd_enable, cmd_wr, cmd_address
// and cmd_data_in hold stable. Only one read is ever outstanding.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int AW          = 23,
  parameter int DW          = 32,
  parameter int CW          = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic          clk100,
  input  logic          rst_p,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    pat_sel,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] addr_lo,
  input  logic [AW-1:0] addr_hi,
  input  logic          cmd_ready,
  output logic          cmd_enable,
  output logic          cmd_wr,
  output logic [AW-1:0] cmd_address,
  output logic [DW-1:0] cmd_data_in,
  input  logic [DW-1:0] data_out,
  input  logic          data_out_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          cfg_err,
  output logic          aborted,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_exp,
  output logic [DW-1:0] first_err_got
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;
  logic [1:0]    pat_sel_q, pat_sel_d;
  logic [DW-1:0] seed_q, seed_d;
  logic          abort_pend_q, abort_pend_d;
  logic          cmd_enable_q, cmd_enable_d, cmd_wr_q, cmd_wr_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic          cfg_err_q, cfg_err_d, aborted_q, aborted_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [AW-1:0] fe_addr_q, fe_addr_d;
  logic [DW-1:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

  logic          gen_load, gen_adv, finish, finish_abort, miss;
  logic [DW-1:0] pattern;

  assign miss = (data_out != pattern);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    pat_sel_d    = pat_sel_q;
    seed_d       = seed_q;
    abort_pend_d = abort_pend_q;
    done_d       = done_q;
    pass_d       = pass_q;
    cfg_err_d    = cfg_err_q;
    aborted_d    = aborted_q;
    err_count_d  = err_count_q;
    fe_addr_d    = fe_addr_q;
    fe_exp_d     = fe_exp_q;
    fe_got_d     = fe_got_q;
    gen_load     = 1'b0;
    gen_adv      = 1'b0;
    finish       = 1'b0;
    finish_abort = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // start has priority over a coincident abort here: abort only acts
        // on a running test.
        if (start) begin
          lo_d         = addr_lo;
          hi_d         = addr_hi;
          pat_sel_d    = pat_sel;
          seed_d       = seed;
          abort_pend_d = 1'b0;
          err_count_d  = '0;
          fe_addr_d    = '0;
          fe_exp_d     = '0;
          fe_got_d     = '0;
          pass_d       = 1'b0;
          done_d       = 1'b0;
          aborted_d    = 1'b0;
          cfg_err_d    = 1'b0;
          if (addr_lo > addr_hi) begin
            cfg_err_d = 1'b1;
            finish    = 1'b1;
          end else begin
            state_d  = WR;
            addr_d   = addr_lo;
            gen_load = 1'b1;
          end
        end
      end
      WR: begin
        // An abort wins even over a coincident last write acceptance.
        if (abort) begin
          finish_abort = 1'b1;
        end else if (cmd_ready) begin
          if (addr_q == hi_q) begin
            state_d  = RD_ISSUE;
            addr_d   = lo_q;
            gen_load = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            gen_adv = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        // A read accepted together with abort is still outstanding; its
        // return is drained in RD_WAIT before the test ends.
        if (cmd_ready) begin
          state_d      = RD_WAIT;
          abort_pend_d = abort;
        end else if (abort) begin
          finish_abort = 1'b1;
        end
      end
      RD_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (data_out_ready) begin
          if (abort || abort_pend_q) begin
            finish_abort = 1'b1;
          end else begin
            if (miss) begin
              if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
              // err_count saturates and never returns to zero, so zero
              // marks the first miscompare of the test.
              if (err_count_q == '0) begin
                fe_addr_d = addr_q;
                fe_exp_d  = pattern;
                fe_got_d  = data_out;
              end
            end
            if ((addr_q == hi_q) || (STOP_ON_ERR && miss)) begin
              finish = 1'b1;
            end else begin
              addr_d  = addr_q + 1'b1;
              gen_adv = 1'b1;
              state_d = RD_ISSUE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish_abort) begin
      aborted_d = 1'b1;
      finish    = 1'b1;
    end
    if (finish) begin
      state_d      = DONE;
      done_d       = 1'b1;
      abort_pend_d = 1'b0;
      pass_d       = (err_count_d == '0) && !finish_abort && !cfg_err_d;
    end

    cmd_enable_d = (state_d == WR) || (state_d == RD_ISSUE);
    cmd_wr_d     = (state_d == WR);
    busy_d       = (state_d == WR) || (state_d == RD_ISSUE) || (state_d == RD_WAIT);
  end

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      pat_sel_q    <= '0;
      seed_q       <= '0;
      abort_pend_q <= 1'b0;
      cmd_enable_q <= 1'b0;
      cmd_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      aborted_q    <= 1'b0;
      err_count_q  <= '0;
      fe_addr_q    <= '0;
      fe_exp_q     <= '0;
      fe_got_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      pat_sel_q    <= pat_sel_d;
      seed_q       <= seed_d;
      abort_pend_q <= abort_pend_d;
      cmd_enable_q <= cmd_enable_d;
      cmd_wr_q     <= cmd_wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      cfg_err_q    <= cfg_err_d;
      aborted_q    <= aborted_d;
      err_count_q  <= err_count_d;
      fe_addr_q    <= fe_addr_d;
      fe_exp_q     <= fe_exp_d;
      fe_got_q     <= fe_got_d;
    end
  end

  tester_pattern_gen #(.AW(AW), .DW(DW)) u_pattern_gen (
    .clk100  (clk100),
    .rst_p   (rst_p),
    .load    (gen_load),
    .advance (gen_adv),
    .pat_sel (pat_sel_d),
    .seed    (seed_d),
    .addr    (addr_d),
    .idx     (addr_d - lo_d),
    .pattern (pattern)
  );

  assign cmd_enable     = cmd_enable_q;
  assign cmd_wr         = cmd_wr_q;
  assign cmd_address    = addr_q;
  assign cmd_data_in    = pattern;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign cfg_err        = cfg_err_q;
  assign aborted        = aborted_q;
  assign err_count      = err_count_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester. Two instances share stimulus:
// g[0] runs the full window (STOP_ON_ERR=0), g[1] stops at the first
// miscompare (STOP_ON_ERR=1). Each has a small SDRAM model that stores
// writes, returns reads three cycles after acceptance, optionally corrupts
// addresses 5 and 9, and flags handshake stability violations.
module tb_sdram_pattern_tester;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk100 = 1'b0;
  logic          rst_p  = 1'b1;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic [1:0]    pat_sel = 2'd0;
  logic [DW-1:0] seed    = '0;
  logic [AW-1:0] addr_lo = '0;
  logic [AW-1:0] addr_hi = '0;
  logic          cmd_ready = 1'b1;
  logic          rand_ready = 1'b0;
  logic          corrupt = 1'b0;
  logic          clr = 1'b0;
  int            cyc = 0;

  int total = 0;
  int bad   = 0;
  int done_cyc;
  logic timed_out;

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;
  always @(posedge clk100) cmd_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  for (genvar k = 0; k < 2; k++) begin : g
    logic          cmd_enable, cmd_wr, busy, done, pass, cfg_err, aborted;
    logic [AW-1:0] cmd_address, first_err_addr;
    logic [DW-1:0] cmd_data_in, first_err_exp, first_err_got;
    logic [DW-1:0] data_out = '0;
    logic          data_out_ready = 1'b0;
    logic [CW-1:0] err_count;

    sdram_pattern_tester #(.AW(AW), .DW(DW), .CW(CW), .STOP_ON_ERR(k == 1)) u_dut (
      .clk100(clk100), .rst_p(rst_p), .start(start), .abort(abort),
      .pat_sel(pat_sel), .seed(seed), .addr_lo(addr_lo), .addr_hi(addr_hi),
      .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
      .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
      .data_out(data_out), .data_out_ready(data_out_ready),
      .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
      .aborted(aborted), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
      .first_err_got(first_err_got)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            wr_cnt = 0, rd_cnt = 0, en_cnt = 0, rd6 = 0, viol = 0;
    int            last_dv_edge = 0;
    logic          pend = 1'b0, stall_q = 1'b0;
    logic [1:0]    pend_cnt = '0;
    logic [AW-1:0] pend_addr = '0, s_addr = '0;
    logic          s_wr = 1'b0;
    logic [DW-1:0] s_data = '0;

    function automatic logic [DW-1:0] corr(input logic [AW-1:0] a);
      if (!corrupt) return '0;
      if (a == 8'd5) return 32'h8;
      if (a == 8'd9) return 32'h1;
      return '0;
    endfunction

    always @(posedge clk100 or posedge rst_p) begin
      if (rst_p) begin
        pend <= 1'b0;
        stall_q <= 1'b0;
        data_out_ready <= 1'b0;
      end else begin
        data_out_ready <= 1'b0;
        if (clr) begin
          wr_cnt <= 0; rd_cnt <= 0; en_cnt <= 0; rd6 <= 0; viol <= 0;
        end else begin
          if (stall_q && !(cmd_enable && cmd_address == s_addr && cmd_wr == s_wr &&
                           (!s_wr || cmd_data_in == s_data)))
            viol <= viol + 1;
          if (cmd_enable) en_cnt <= en_cnt + 1;
          if (cmd_enable && cmd_ready) begin
            if (cmd_wr) begin
              mem[cmd_address] <= cmd_data_in;
              wr_cnt <= wr_cnt + 1;
            end else begin
              if (pend) viol <= viol + 1;
              rd_cnt <= rd_cnt + 1;
              if (cmd_address == 8'd6) rd6 <= rd6 + 1;
            end
          end
        end
        stall_q <= cmd_enable && !cmd_ready;
        s_addr  <= cmd_address;
        s_wr    <= cmd_wr;
        s_data  <= cmd_data_in;
        if (cmd_enable && cmd_ready && !cmd_wr) begin
          pend      <= 1'b1;
          pend_cnt  <= 2'd2;
          pend_addr <= cmd_address;
        end else if (pend) begin
          if (pend_cnt == 2'd0) begin
            data_out_ready <= 1'b1;
            data_out <= mem[pend_addr] ^ corr(pend_addr);
            pend <= 1'b0;
          end else begin
            pend_cnt <= pend_cnt - 2'd1;
          end
        end
        if (data_out_ready) last_dv_edge <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk100);
  endtask

  task automatic clear_model();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] p, input logic [DW-1:0] s,
                             input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    pat_sel = p; seed = s; addr_lo = lo; addr_hi = hi;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    done_cyc = -1;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (g[0].done && done_cyc < 0) done_cyc = cyc;
      if (g[0].done && g[1].done) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  initial begin
    // ---- reset state
    tick(3);
    check("rst_status", {g[0].busy, g[0].done, g[0].pass, g[0].cfg_err, g[0].aborted, g[0].cmd_enable}, 0);
    check("rst_err_count", g[0].err_count, 0);
    rst_p = 1'b0;
    tick(2);

    // ---- incrementing pattern, ideal controller
    clear_model();
    pulse_start(2'd0, 32'h100, 8'd0, 8'd15);
    check("first_cmd", {g[0].cmd_enable, g[0].cmd_wr, g[0].cmd_address, g[0].cmd_data_in}, {2'b11, 8'd0, 32'h100});
    wait_done(2000);
    check("inc_timeout", timed_out, 0);
    check("inc_pass", {g[0].done, g[0].pass, g[0].busy}, 3'b110);
    check("inc_err_count", g[0].err_count, 0);
    check("inc_counts", {g[0].wr_cnt[7:0], g[0].rd_cnt[7:0]}, {8'd16, 8'd16});
    check("inc_mem0", g[0].mem[0], 32'h100);
    check("inc_mem15", g[0].mem[15], 32'h10F);
    check("done_latency", done_cyc, g[0].last_dv_edge + 1);

    // ---- walking ones with a stalling controller
    clear_model();
    rand_ready = 1'b1;
    pulse_start(2'd2, 32'h0, 8'd8, 8'd47);
    wait_done(4000);
    rand_ready = 1'b0;
    check("walk_timeout", timed_out, 0);
    check("walk_pass", {g[0].done, g[0].pass}, 2'b11);
    check("walk_counts", {g[0].wr_cnt[7:0], g[0].rd_cnt[7:0]}, {8'd40, 8'd40});
    check("walk_stable", g[0].viol, 0);
    check("walk_mem8", g[0].mem[8], 32'h1);
    check("walk_mem39", g[0].mem[39], 32'h8000_0000);
    check("walk_mem40", g[0].mem[40], 32'h1);
    check("walk_mem47", g[0].mem[47], 32'h80);

    // ---- address pattern with corrupted reads of 5 and 9
    clear_model();
    corrupt = 1'b1;
    pulse_start(2'd1, 32'h0, 8'd0, 8'd15);
    wait_done(2000);
    corrupt = 1'b0;
    check("err_timeout", timed_out, 0);
    check("err_count_full", g[0].err_count, 2);
    check("err_first", {g[0].first_err_addr, g[0].first_err_exp, g[0].first_err_got}, {8'd5, 32'd5, 32'hD});
    check("err_pass_full", {g[0].done, g[0].pass}, 2'b10);
    check("stop_err_count", g[1].err_count, 1);
    check("stop_reads", {g[1].rd_cnt[7:0], g[1].rd6[7:0]}, {8'd6, 8'd0});
    check("stop_first_addr", g[1].first_err_addr, 5);
    check("stop_pass", {g[1].done, g[1].pass}, 2'b10);

    // ---- inverted window
    clear_model();
    pulse_start(2'd0, 32'h0, 8'd10, 8'd3);
    tick();
    check("cfg_status", {g[0].done, g[0].cfg_err, g[0].pass, g[0].busy}, 4'b1100);
    tick(3);
    check("cfg_no_cmd", g[0].en_cnt + g[1].en_cnt, 0);

    // ---- LFSR with seed 0, abort while waiting for the read of address 4
    clear_model();
    pulse_start(2'd3, 32'h0, 8'd0, 8'd15);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (g[0].rd_cnt == 5) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    check("abort_reach_timeout", timed_out, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy_drain", g[0].busy, 1);
    wait_done(200);
    check("abort_timeout", timed_out, 0);
    tick(4);
    check("abort_status", {g[0].done, g[0].aborted, g[0].pass, g[0].cmd_enable}, 4'b1100);
    check("abort_counts", {g[0].wr_cnt[7:0], g[0].rd_cnt[7:0]}, {8'd16, 8'd5});
    check("lfsr_mem0", g[0].mem[0], 32'h1);
    check("lfsr_mem1", g[0].mem[1], 32'h8020_0003);
    check("lfsr_mem2", g[0].mem[2], 32'hC030_0002);
    check("lfsr_mem3", g[0].mem[3], 32'h6018_0001);

    // ---- reset in the middle of the write phase
    clear_model();
    pulse_start(2'd0, 32'h55, 8'd0, 8'd15);
    tick(3);
    check("midwr_busy", {g[0].busy, g[0].cmd_wr}, 2'b11);
    rst_p = 1'b1;
    #1;
    check("midwr_rst_status", {g[0].busy, g[0].done, g[0].pass, g[0].cfg_err, g[0].aborted, g[0].cmd_enable, g[0].cmd_wr}, 0);
    check("midwr_rst_data", {g[0].cmd_address, g[0].cmd_data_in, g[0].err_count}, 0);
    tick(2);
    rst_p = 1'b0;
    tick(2);

    // ---- start and abort together in IDLE, then a clean LFSR run
    clear_model();
    abort = 1'b1;
    pulse_start(2'd3, 32'h1234_5678, 8'd0, 8'd15);
    abort = 1'b0;
    wait_done(2000);
    check("restart_timeout", timed_out, 0);
    check("restart_status", {g[0].done, g[0].pass, g[0].aborted, g[0].cfg_err}, 4'b1100);
    check("restart_counts", {g[0].wr_cnt[7:0], g[0].rd_cnt[7:0]}, {8'd16, 8'd16});
    check("restart_mem0", g[0].mem[0], 32'h1234_5678);
    check("restart_stable", g[0].viol + g[1].viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
